fwd_scoreboard: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the pipelined RV32 core.
- Keeps its own DEPTH-entry shift register of in-flight destination writes: stage 1 = EX/MEM, stage 2 = MEM/WB, and so on.
- For each of NUM_SRC source-operand channels of the instruction in EX, it reports the nearest producing stage.
- Requests a stall when that producer is a load whose data is not yet available. Keeps a saturating count of stall cycles.

---
 rtl/fwd_scoreboard.sv | 83 ++++++++
 tb/tb_fwd_scoreboard.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks DEPTH in-flight destination writes
// after EX and reports, per source channel, the nearest producing stage.
module fwd_scoreboard #(
  parameter int unsigned NUM_SRC          = 3,
  parameter int unsigned DEPTH            = 2,
  parameter int unsigned LOAD_READY_STAGE = 2,
  parameter int unsigned CNT_W            = 16,
  localparam int unsigned SEL_W           = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  input  logic                     ex_valid_i,
  input  logic [4:0]               ex_rd_i,
  input  logic                     ex_regwrite_i,
  input  logic                     ex_is_load_i,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  input  logic [NUM_SRC*5-1:0]     src_addr_i,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
  output logic                     load_use_stall_o,
  output logic [NUM_SRC-1:0]       stall_src_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  // Index i holds stage i+1 (index 0 = EX/MEM).
  logic [DEPTH-1:0]      ent_v;
  logic [DEPTH-1:0][4:0] ent_rd;
  logic [DEPTH-1:0]      ent_we;
  logic [DEPTH-1:0]      ent_ld;
  logic [DEPTH-1:0]      live;
  logic                  bubble;

  always_comb begin
    live = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      live[i] = ent_v[i] & ent_we[i] & (ent_rd[i] != 5'd0);
    end
  end

  // Oldest stage scanned first so the nearest (youngest) match overwrites it.
  always_comb begin
    fwd_sel_o   = '0;
    stall_src_o = '0;
    for (int unsigned c = 0; c < NUM_SRC; c++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (src_valid_i[c] && live[DEPTH-1-j] &&
            (ent_rd[DEPTH-1-j] == src_addr_i[5*c +: 5])) begin
          fwd_sel_o[c*SEL_W +: SEL_W] = SEL_W'(DEPTH - j);
          stall_src_o[c] = ent_ld[DEPTH-1-j] && ((DEPTH - j) < LOAD_READY_STAGE);
        end
      end
    end
  end

  assign load_use_stall_o = |stall_src_o;
  assign bubble           = load_use_stall_o | flush_i | ~ex_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_v       <= '0;
      ent_rd      <= '0;
      ent_we      <= '0;
      ent_ld      <= '0;
      stall_cnt_o <= '0;
    end else if (!hold_i) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        ent_v[i]  <= ent_v[i-1];
        ent_rd[i] <= ent_rd[i-1];
        ent_we[i] <= ent_we[i-1];
        ent_ld[i] <= ent_ld[i-1];
      end
      ent_v[0]  <= ~bubble;
      ent_rd[0] <= ex_rd_i;
      ent_we[0] <= ex_regwrite_i;
      ent_ld[0] <= ex_is_load_i;
      if (load_use_stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench: default-parameter instance plus a deep, slow-load, 2-bit-counter
// instance that exercises repeated stalls and counter saturation.
module tb_fwd_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold;
  logic       flush;
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_we;
  logic       ex_ld;
  logic [2:0] src_valid;
  logic [14:0] src_addr;

  logic [5:0]  sel;
  logic        stall;
  logic [2:0]  stall_src;
  logic [15:0] cnt;

  logic [8:0]  sat_sel;
  logic        sat_stall;
  logic [2:0]  sat_src;
  logic [1:0]  sat_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_scoreboard #(.NUM_SRC(3), .DEPTH(2), .LOAD_READY_STAGE(2), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_we), .ex_is_load_i(ex_ld),
    .src_valid_i(src_valid), .src_addr_i(src_addr),
    .fwd_sel_o(sel), .load_use_stall_o(stall), .stall_src_o(stall_src), .stall_cnt_o(cnt)
  );

  fwd_scoreboard #(.NUM_SRC(3), .DEPTH(4), .LOAD_READY_STAGE(4), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_we), .ex_is_load_i(ex_ld),
    .src_valid_i(src_valid), .src_addr_i(src_addr),
    .fwd_sel_o(sat_sel), .load_use_stall_o(sat_stall), .stall_src_o(sat_src),
    .stall_cnt_o(sat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic we, input logic ld);
    ex_valid = v;
    ex_rd    = rd;
    ex_we    = we;
    ex_ld    = ld;
  endtask

  task automatic set_src(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2);
    src_valid = v;
    src_addr  = {a2, a1, a0};
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(3'b000, 5'd0, 5'd0, 5'd0);
    tick(); tick();

    // Reset state
    set_src(3'b111, 5'd5, 5'd6, 5'd7);
    #1;
    check("in_rst_sel", 32'(sel), 32'd0);
    check("in_rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_src", 32'(stall_src), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);

    // Nearest producer wins
    set_src(3'b000, 5'd0, 5'd0, 5'd0);
    issue(1'b1, 5'd5, 1'b1, 1'b0); tick();
    issue(1'b1, 5'd5, 1'b1, 1'b0); tick();
    issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(3'b001, 5'd5, 5'd0, 5'd0);
    #1;
    check("prio_near", 32'(sel), 32'd1);
    tick();
    check("prio_old", 32'(sel), 32'd2);
    tick();
    check("drained", 32'(sel), 32'd0);

    // x0 never matches; invalid channel masked
    set_src(3'b000, 5'd0, 5'd0, 5'd0);
    issue(1'b1, 5'd0, 1'b1, 1'b0); tick();
    issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(3'b001, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_sel", 32'(sel), 32'd0);
    issue(1'b1, 5'd8, 1'b1, 1'b0); tick();
    issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(3'b101, 5'd1, 5'd8, 5'd2);
    #1;
    check("mask_sel", 32'(sel), 32'd0);
    set_src(3'b010, 5'd1, 5'd8, 5'd2);
    #1;
    check("ch1_sel", 32'(sel), 32'b000100);
    tick(); tick();

    // Load-use on two channels
    set_src(3'b000, 5'd0, 5'd0, 5'd0);
    issue(1'b1, 5'd9, 1'b1, 1'b1); tick();
    issue(1'b1, 5'd11, 1'b1, 1'b0);
    set_src(3'b101, 5'd9, 5'd0, 5'd9);
    #1;
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_src", 32'(stall_src), 32'b101);
    check("lu_sel", 32'(sel), 32'b010001);
    check("lu_cnt0", 32'(cnt), 32'd0);
    tick();
    check("lu_sel2", 32'(sel), 32'b100010);
    check("lu_clear", 32'(stall), 32'd0);
    check("lu_cnt1", 32'(cnt), 32'd1);
    issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(3'b000, 5'd0, 5'd0, 5'd0);
    tick(); tick();

    // Hold freezes entries and counter
    issue(1'b1, 5'd12, 1'b1, 1'b1); tick();
    issue(1'b1, 5'd13, 1'b1, 1'b0);
    set_src(3'b001, 5'd12, 5'd0, 5'd0);
    #1;
    check("h_stall0", 32'(stall), 32'd1);
    hold = 1'b1;
    tick();
    check("h_stall1", 32'(stall), 32'd1);
    tick(); tick();
    check("h_stall3", 32'(stall), 32'd1);
    check("h_sel", 32'(sel), 32'd1);
    check("h_cnt", 32'(cnt), 32'd1);
    hold = 1'b0;
    tick();
    check("h_rel_sel", 32'(sel), 32'd2);
    check("h_rel_stall", 32'(stall), 32'd0);
    check("h_rel_cnt", 32'(cnt), 32'd2);

    // Flush inserts bubble
    flush = 1'b1;
    issue(1'b1, 5'd10, 1'b1, 1'b0);
    set_src(3'b000, 5'd0, 5'd0, 5'd0);
    tick();
    flush = 1'b0;
    issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(3'b001, 5'd10, 5'd0, 5'd0);
    #1;
    check("flush_sel", 32'(sel), 32'd0);
    check("flush_cnt", 32'(cnt), 32'd2);

    // Async reset mid-stall
    issue(1'b1, 5'd14, 1'b1, 1'b1);
    set_src(3'b000, 5'd0, 5'd0, 5'd0);
    tick();
    issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(3'b001, 5'd14, 5'd0, 5'd0);
    #1;
    check("mr_pre", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("mr_stall", 32'(stall), 32'd0);
    check("mr_sel", 32'(sel), 32'd0);
    check("mr_cnt", 32'(cnt), 32'd0);
    check("mr_sat_cnt", 32'(sat_cnt), 32'd0);
    tick();
    rst = 1'b0;

    // Deep instance: repeated stalls until stage 4, then saturation
    set_src(3'b000, 5'd0, 5'd0, 5'd0);
    issue(1'b1, 5'd15, 1'b1, 1'b1); tick();
    issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(3'b001, 5'd15, 5'd0, 5'd0);
    #1;
    check("sat_s1", 32'(sat_stall), 32'd1);
    check("sat_sel1", 32'(sat_sel), 32'd1);
    tick();
    check("sat_s2", 32'(sat_stall), 32'd1);
    check("sat_sel2", 32'(sat_sel), 32'd2);
    check("sat_cnt1", 32'(sat_cnt), 32'd1);
    tick();
    check("sat_sel3", 32'(sat_sel), 32'd3);
    check("sat_cnt2", 32'(sat_cnt), 32'd2);
    tick();
    check("sat_s4", 32'(sat_stall), 32'd0);
    check("sat_sel4", 32'(sat_sel), 32'd4);
    check("sat_cnt3", 32'(sat_cnt), 32'd3);
    set_src(3'b001, 5'd16, 5'd0, 5'd0);
    issue(1'b1, 5'd16, 1'b1, 1'b1); tick();
    issue(1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("sat_s5", 32'(sat_stall), 32'd1);
    tick(); tick(); tick();
    check("sat_hold3", 32'(sat_cnt), 32'd3);
    check("sat_end_stall", 32'(sat_stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
